// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and PC increment for the fetch/step stage
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, CAPTURE, HOLD} fetch_state_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key, emitting one pulse per accepted press
// ports: clk, rst (sync, active-high), key_n (raw async key, low = pressed), press_pulse (one clock per press)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl, done;
  logic [CW-1:0] cnt;
  // cnt counts consecutive samples that disagree with the accepted level
  assign done = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      cnt <= (s2 == lvl || done) ? '0 : cnt + 1'b1;
      lvl <= done ? s2 : lvl;
      press_pulse <= done & lvl;
    end
  end
endmodule

// File: rtl/fetch_step_ctrl.sv
// fetch_step_ctrl: owns the PC, fetches from a 1-cycle ROM and holds instr/pc until a key or run-tick advance
// ports: clk, rst (sync, active-high), key_step_n, sw_run, br_taken, br_target -> imem_addr/imem_rdata ROM port,
//        instr, pc, instr_valid, step_pulse
module fetch_step_ctrl
  import fetch_pkg::*;
#(
  parameter int          IMEM_AW         = 8,
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 500_000,
  parameter int          RUN_DIV         = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_step_n,
  input  logic               sw_run,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic [31:0]        pc,
  output logic               instr_valid,
  output logic               step_pulse
);
  localparam int RW = $clog2(RUN_DIV + 1);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q;
  logic [RW-1:0] run_cnt;
  logic sw_run_q, press, hold, mode_chg, tick, advance;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .key_n(key_step_n),
    .press_pulse(press)
  );
  assign hold = state_q == HOLD;
  assign mode_chg = sw_run ^ sw_run_q;
  // a mode change cycle can never tick, so switching modes never advances by itself
  assign tick = hold & sw_run & ~mode_chg & (run_cnt == RW'(RUN_DIV - 1));
  assign advance = hold & (sw_run ? tick : press);
  assign step_pulse = advance;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  always_comb begin
    state_d = state_q;
    state_d = advance ? FETCH : (state_q == FETCH) ? CAPTURE : (state_q == CAPTURE) ? HOLD : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      pc <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
      run_cnt <= '0;
      sw_run_q <= sw_run;
    end else begin
      state_q <= state_d;
      sw_run_q <= sw_run;
      run_cnt <= (hold & sw_run & ~mode_chg & ~tick) ? run_cnt + 1'b1 : '0;
      if (advance) begin
        pc_q <= br_taken ? (br_target & ~32'h3) : pc_q + PC_INC;
        instr_valid <= 1'b0;
      end
      if (state_q == CAPTURE) begin
        instr <= imem_rdata;
        pc <= pc_q;
        instr_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_step_ctrl.sv
// tb_fetch_step_ctrl: directed scoreboard bench for fetch_step_ctrl
module tb_fetch_step_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_step_n = 1'b1, sw_run = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [7:0] imem_addr;
  logic [31:0] imem_rdata, instr, pc;
  logic instr_valid, step_pulse;
  int vectors = 0, miscompares = 0, steps = 0, cyc_n = 0, last_run = -1;
  logic prev_valid = 1'b0;
  logic [63:0] exp_q[$];
  fetch_step_ctrl #(.IMEM_AW(8), .RESET_PC(32'h0), .DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
    .clk(clk), .rst(rst), .key_step_n(key_step_n), .sw_run(sw_run), .br_taken(br_taken),
    .br_target(br_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
    .pc(pc), .instr_valid(instr_valid), .step_pulse(step_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= 32'hE3A00000 + 32'(imem_addr);
  function automatic logic [31:0] rom(input int i);
    return 32'hE3A00000 + 32'(i);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int n);
    key_step_n = 1'b0;
    cyc(n);
    key_step_n = 1'b1;
    cyc(15);
  endtask
  always @(negedge clk) begin
    logic [63:0] e;
    cyc_n++;
    if (!rst && instr_valid === 1'b1 && !prev_valid) begin
      chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", pc, e[63:32]);
        chk("sb_instr", instr, e[31:0]);
      end
    end
    prev_valid = (instr_valid === 1'b1);
    if (step_pulse === 1'b1) begin
      steps++;
      if (sw_run) begin
        if (last_run >= 0) chk("run_gap", 32'(cyc_n - last_run), 32'd10);
        last_run = cyc_n;
      end
    end
    if (!sw_run) last_run = -1;
  end
  initial begin
    cyc(3);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_step", 32'(step_pulse), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    exp_q.push_back({32'h0, rom(0)});
    rst = 1'b0;
    cyc(2);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_instr", instr, rom(0));
    cyc(20);
    chk("idle_steps", 32'(steps), 32'd0);
    exp_q.push_back({32'h4, rom(1)});
    press(10);
    chk("step_count", 32'(steps), 32'd1);
    chk("step_pc", pc, 32'h4);
    chk("step_instr", instr, rom(1));
    key_step_n = 1'b0;
    cyc(3);
    key_step_n = 1'b1;
    cyc(15);
    chk("glitch_steps", 32'(steps), 32'd1);
    chk("glitch_pc", pc, 32'h4);
    br_taken = 1'b1;
    br_target = 32'h13;
    exp_q.push_back({32'h10, rom(4)});
    press(10);
    br_taken = 1'b0;
    chk("br_pc", pc, 32'h10);
    chk("br_instr", instr, rom(4));
    for (int i = 5; i <= 8; i++) exp_q.push_back({32'(4 * i), rom(i)});
    sw_run = 1'b1;
    cyc(5);
    key_step_n = 1'b0;
    cyc(10);
    key_step_n = 1'b1;
    cyc(25);
    sw_run = 1'b0;
    cyc(10);
    chk("run_steps", 32'(steps), 32'd6);
    chk("run_pc", pc, 32'h20);
    br_taken = 1'b1;
    br_target = 32'h3FC;
    exp_q.push_back({32'h3FC, rom(255)});
    press(10);
    br_taken = 1'b0;
    chk("pre_wrap_pc", pc, 32'h3FC);
    exp_q.push_back({32'h400, rom(0)});
    press(10);
    chk("wrap_pc", pc, 32'h400);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_instr", instr, rom(0));
    chk("wrap_steps", 32'(steps), 32'd8);
    key_step_n = 1'b0;
    for (int i = 0; i < 20 && step_pulse !== 1'b1; i++) cyc(1);
    chk("abort_adv", 32'(step_pulse), 32'd1);
    cyc(2);
    chk("abort_capture_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    key_step_n = 1'b1;
    cyc(1);
    chk("abort_rst_valid", 32'(instr_valid), 32'd0);
    chk("abort_rst_pc", pc, 32'h0);
    chk("abort_rst_instr", instr, 32'h0);
    exp_q.push_back({32'h0, rom(0)});
    rst = 1'b0;
    cyc(2);
    chk("refetch_valid", 32'(instr_valid), 32'd1);
    chk("refetch_pc", pc, 32'h0);
    chk("refetch_instr", instr, rom(0));
    cyc(5);
    chk("q_drained", 32'(exp_q.size()), 32'd0);
    chk("total_steps", 32'(steps), 32'd9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
